heading_bank: RTL and testbench



---
 rtl/heading_bank_if.sv | 25 ++
 rtl/heading_bank.sv | 142 ++++++++++++++
 tb/tb_heading_bank.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/heading_bank_if.sv
// Key/switch and display-side signal bundle for heading_bank.
interface heading_bank_if #(
    parameter int unsigned DATA_W   = 7,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned SEL_W    = 1
) ();
    logic                         request;
    logic                         confirm;
    logic [SEL_W+DATA_W-1:0]      inputData;
    logic [CHANNELS*DATA_W-1:0]   dataOut;
    logic [1:0]                   state;
    logic                         busy;
    logic                         error;
    logic                         timeout;

    modport master (
        output request, confirm, inputData,
        input  dataOut, state, busy, error, timeout
    );

    modport slave (
        input  request, confirm, inputData,
        output dataOut, state, busy, error, timeout
    );
endinterface

// File: rtl/heading_bank.sv
// Key-driven capture/commit of a {select, data} word into one of CHANNELS registers.
// Optional ARMED timeout is built when HEADING_TIMEOUT_EN is defined.
module heading_bank #(
    parameter int unsigned DATA_W   = 7,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned SEL_W    = 1,
    parameter int unsigned TIMEOUT  = 1000
) (
    input logic           clock,
    input logic           reset,
    heading_bank_if.slave bus
);
    localparam int unsigned WORD_W = SEL_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    if (CHANNELS < 2 || CHANNELS > 16 || (1 << SEL_W) < CHANNELS || TIMEOUT < 2) begin : g_param_check
        $error("heading_bank: illegal parameter combination");
    end

    state_t                           state_q, state_d;
    logic                             req_prev_q, cnf_prev_q;
    logic [WORD_W-1:0]                hold_q, hold_d;
    logic [CHANNELS-1:0][DATA_W-1:0]  chan_q, chan_d;
    logic                             busy_q, busy_d;
    logic                             error_q, error_d;
    logic                             timeout_q, timeout_d;

    logic                             req_edge;
    logic                             cnf_edge;
    logic                             sel_valid;
    logic                             expire;
    logic [SEL_W-1:0]                 hold_sel;

    assign req_edge  = bus.request & ~req_prev_q;
    assign cnf_edge  = bus.confirm & ~cnf_prev_q;
    assign hold_sel  = hold_q[WORD_W-1 -: SEL_W];
    assign sel_valid = (32'(hold_sel) < CHANNELS);

`ifdef HEADING_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Cleared on every (re-)entry to ARMED, counts while ARMED.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == ARMED && (state_q != ARMED || req_edge)) begin
            cnt_d = '0;
        end else if (state_q == ARMED) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign expire = (state_q == ARMED) && (cnt_q == CNT_W'(TIMEOUT - 2));

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    // Next state; within ARMED, confirm beats request, which beats expiry.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        chan_d    = chan_q;
        error_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_edge) begin
                    hold_d  = bus.inputData;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (cnf_edge) begin
                    if (sel_valid) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = IDLE;
                        error_d = 1'b1;
                    end
                end else if (req_edge) begin
                    hold_d = bus.inputData;
                end else if (expire) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            COMMIT: begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    if (hold_sel == SEL_W'(c)) begin
                        chan_d[c] = hold_q[DATA_W-1:0];
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Key prev registers reset high so a key held through reset is not an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            req_prev_q <= 1'b1;
            cnf_prev_q <= 1'b1;
            hold_q     <= '0;
            chan_q     <= '0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_prev_q <= bus.request;
            cnf_prev_q <= bus.confirm;
            hold_q     <= hold_d;
            chan_q     <= chan_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.dataOut = chan_q;
    assign bus.state   = state_q;
    assign bus.busy    = busy_q;
    assign bus.error   = error_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_heading_bank.sv
// Directed bench: a 4-channel and a 3-channel heading_bank driven by identical key stimulus.
module tb_heading_bank;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req   = 1'b0;
    logic       cnf   = 1'b0;
    logic [8:0] din   = '0;

    int vectors = 0;
    int fails   = 0;

    heading_bank_if #(.DATA_W(7), .CHANNELS(4), .SEL_W(2)) if4 ();
    heading_bank_if #(.DATA_W(7), .CHANNELS(3), .SEL_W(2)) if3 ();

    assign if4.request   = req;
    assign if4.confirm   = cnf;
    assign if4.inputData = din;
    assign if3.request   = req;
    assign if3.confirm   = cnf;
    assign if3.inputData = din;

    heading_bank #(.DATA_W(7), .CHANNELS(4), .SEL_W(2), .TIMEOUT(8)) u_dut4 (
        .clock(clock), .reset(reset), .bus(if4));
    heading_bank #(.DATA_W(7), .CHANNELS(3), .SEL_W(2), .TIMEOUT(8)) u_dut3 (
        .clock(clock), .reset(reset), .bus(if3));

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_req(input logic [8:0] w);
        din = w;
        req = 1'b1;
        step();
        req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vectors++; if (if4.dataOut !== 28'h0) begin fails++; $display("FAIL reset_data4: got %h want 0", if4.dataOut); end
        vectors++; if (if4.state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", if4.state); end
        vectors++; if ({if4.busy, if4.error, if4.timeout} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {if4.busy, if4.error, if4.timeout}); end
        vectors++; if (if3.dataOut !== 21'h0) begin fails++; $display("FAIL reset_data3: got %h want 0", if3.dataOut); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_commit();
        pulse_req(9'b10_1010101);
        vectors++; if (if4.state !== 2'd1 || if4.busy !== 1'b1) begin fails++; $display("FAIL commit_armed: got state %0d busy %b want 1 1", if4.state, if4.busy); end
        cnf = 1'b1;
        step();
        vectors++; if (if4.state !== 2'd2) begin fails++; $display("FAIL commit_state: got %0d want 2", if4.state); end
        vectors++; if (if4.dataOut !== 28'h0) begin fails++; $display("FAIL commit_early: got %h want 0", if4.dataOut); end
        cnf = 1'b0;
        step();
        vectors++; if (if4.state !== 2'd0 || if4.busy !== 1'b0) begin fails++; $display("FAIL commit_idle: got state %0d busy %b want 0 0", if4.state, if4.busy); end
        vectors++; if (if4.dataOut !== 28'h0154000) begin fails++; $display("FAIL commit_data4: got %h want 0154000", if4.dataOut); end
        vectors++; if (if3.dataOut !== 21'h154000) begin fails++; $display("FAIL commit_data3: got %h want 154000", if3.dataOut); end
    endtask

    task automatic test_keys_through_reset();
        reset = 1'b1;
        req   = 1'b1;
        cnf   = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        vectors++; if (if4.state !== 2'd0) begin fails++; $display("FAIL held_keys_state: got %0d want 0", if4.state); end
        step();
        vectors++; if (if4.state !== 2'd0 || if4.busy !== 1'b0) begin fails++; $display("FAIL held_keys_idle: got state %0d busy %b want 0 0", if4.state, if4.busy); end
        vectors++; if (if4.dataOut !== 28'h0) begin fails++; $display("FAIL held_keys_data: got %h want 0", if4.dataOut); end
        req = 1'b0;
        cnf = 1'b0;
        step();
    endtask

    task automatic test_invalid_select();
        pulse_req(9'b11_0001111);
        cnf = 1'b1;
        step();
        vectors++; if (if3.error !== 1'b1) begin fails++; $display("FAIL invalid_error: got %b want 1", if3.error); end
        vectors++; if (if3.state !== 2'd0 || if3.busy !== 1'b0) begin fails++; $display("FAIL invalid_state: got state %0d busy %b want 0 0", if3.state, if3.busy); end
        vectors++; if (if4.state !== 2'd2 || if4.error !== 1'b0) begin fails++; $display("FAIL valid_sel3: got state %0d error %b want 2 0", if4.state, if4.error); end
        cnf = 1'b0;
        step();
        vectors++; if (if3.error !== 1'b0) begin fails++; $display("FAIL invalid_pulse_len: got %b want 0", if3.error); end
        vectors++; if (if3.dataOut !== 21'h0) begin fails++; $display("FAIL invalid_data: got %h want 0", if3.dataOut); end
        vectors++; if (if4.dataOut !== 28'h1E00000) begin fails++; $display("FAIL ch3_data4: got %h want 1E00000", if4.dataOut); end
    endtask

    task automatic test_relatch();
        pulse_req(9'b01_0000011);
        step();
        pulse_req(9'b01_1111111);
        vectors++; if (if4.state !== 2'd1) begin fails++; $display("FAIL relatch_armed: got %0d want 1", if4.state); end
        cnf = 1'b1;
        step();
        cnf = 1'b0;
        step();
        vectors++; if (if4.dataOut !== 28'h1E03F80) begin fails++; $display("FAIL relatch_data4: got %h want 1E03F80", if4.dataOut); end
        vectors++; if (if3.dataOut !== 21'h003F80) begin fails++; $display("FAIL relatch_data3: got %h want 003F80", if3.dataOut); end
    endtask

    task automatic test_timeout();
`ifdef HEADING_TIMEOUT_EN
        pulse_req(9'b00_0010001);
        for (int k = 1; k <= 6; k++) begin
            step();
            vectors++; if (if4.state !== 2'd1 || if4.timeout !== 1'b0) begin fails++; $display("FAIL timeout_early k=%0d: got state %0d timeout %b want 1 0", k, if4.state, if4.timeout); end
        end
        step();
        vectors++; if (if4.timeout !== 1'b1 || if4.state !== 2'd0) begin fails++; $display("FAIL timeout_pulse: got timeout %b state %0d want 1 0", if4.timeout, if4.state); end
        step();
        vectors++; if (if4.timeout !== 1'b0) begin fails++; $display("FAIL timeout_len: got %b want 0", if4.timeout); end
        vectors++; if (if4.dataOut !== 28'h1E03F80) begin fails++; $display("FAIL timeout_data: got %h want 1E03F80", if4.dataOut); end
        pulse_req(9'b00_0101010);
        for (int k = 1; k <= 6; k++) step();
        vectors++; if (if4.state !== 2'd1) begin fails++; $display("FAIL expiry_armed: got %0d want 1", if4.state); end
        cnf = 1'b1;
        step();
        vectors++; if (if4.state !== 2'd2 || if4.timeout !== 1'b0) begin fails++; $display("FAIL expiry_confirm: got state %0d timeout %b want 2 0", if4.state, if4.timeout); end
`else
        pulse_req(9'b00_0101010);
        for (int k = 1; k <= 20; k++) step();
        vectors++; if (if4.state !== 2'd1 || if4.timeout !== 1'b0) begin fails++; $display("FAIL no_timeout: got state %0d timeout %b want 1 0", if4.state, if4.timeout); end
        cnf = 1'b1;
        step();
        vectors++; if (if4.state !== 2'd2) begin fails++; $display("FAIL late_confirm: got %0d want 2", if4.state); end
`endif
        cnf = 1'b0;
        step();
        vectors++; if (if4.dataOut !== 28'h1E03FAA) begin fails++; $display("FAIL ch0_data4: got %h want 1E03FAA", if4.dataOut); end
        vectors++; if (if3.dataOut !== 21'h003FAA) begin fails++; $display("FAIL ch0_data3: got %h want 003FAA", if3.dataOut); end
    endtask

    task automatic test_reset_in_commit();
        pulse_req(9'b10_0110011);
        cnf = 1'b1;
        step();
        vectors++; if (if4.state !== 2'd2) begin fails++; $display("FAIL rc_commit: got %0d want 2", if4.state); end
        reset = 1'b1;
        cnf   = 1'b0;
        step();
        vectors++; if (if4.dataOut !== 28'h0 || if3.dataOut !== 21'h0) begin fails++; $display("FAIL rc_data: got %h %h want 0 0", if4.dataOut, if3.dataOut); end
        vectors++; if (if4.state !== 2'd0) begin fails++; $display("FAIL rc_state: got %0d want 0", if4.state); end
        vectors++; if ({if4.busy, if4.error, if4.timeout} !== 3'b000) begin fails++; $display("FAIL rc_flags: got %b want 000", {if4.busy, if4.error, if4.timeout}); end
        reset = 1'b0;
        step();
        vectors++; if (if4.dataOut !== 28'h0 || if4.state !== 2'd0) begin fails++; $display("FAIL rc_after: got data %h state %0d want 0 0", if4.dataOut, if4.state); end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_keys_through_reset();
        test_invalid_select();
        test_relatch();
        test_timeout();
        test_reset_in_commit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
